// File: rtl/dtw_stream_ctrl.sv
// DTW accelerator front end: register file plus a framed AXI-stream path on one clock.
// Enforces a programmable frame length, repairs tlast, drops overlong tails and buffers in a FIFO.
module dtw_stream_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      i_reg_address,
  input  logic                       i_reg_in_rdy,
  input  logic [DATA_WIDTH-1:0]      i_reg_in_data,
  output logic                       o_reg_in_ack_stb,
  input  logic                       i_reg_out_req,
  output logic                       o_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]      o_reg_out_data,
  output logic                       o_reg_invalid_addr,
  input  logic                       i_axis_in_tvalid,
  output logic                       o_axis_in_tready,
  input  logic                       i_axis_in_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
  output logic                       o_axis_out_tvalid,
  input  logic                       i_axis_out_tready,
  output logic                       o_axis_out_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] AddrControl    = ADDR_WIDTH'('h00);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus     = ADDR_WIDTH'('h04);
  localparam logic [ADDR_WIDTH-1:0] AddrRefLen     = ADDR_WIDTH'('h08);
  localparam logic [ADDR_WIDTH-1:0] AddrVersion    = ADDR_WIDTH'('h0C);
  localparam logic [ADDR_WIDTH-1:0] AddrKey        = ADDR_WIDTH'('h10);
  localparam logic [ADDR_WIDTH-1:0] AddrFrameCount = ADDR_WIDTH'('h14);
  localparam logic [ADDR_WIDTH-1:0] AddrSampleCnt  = ADDR_WIDTH'('h18);

  localparam logic [31:0] VersionValue = 32'h2000_0000;
  localparam logic [31:0] KeyValue     = 32'h0CA7_CAFE;

  typedef enum logic [1:0] {StIdle, StPass, StDiscard} state_e;

  state_e                   state_q;
  logic [LEN_WIDTH-1:0]     cnt_q;
  logic [LEN_WIDTH-1:0]     ref_len_q;
  logic                     enable_q;
  logic                     strict_q;
  logic                     short_err_q;
  logic                     long_err_q;
  logic [31:0]              frame_cnt_q;
  logic [31:0]              sample_cnt_q;
  logic [AXIS_DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [PtrW:0]            wr_ptr_q;
  logic [PtrW:0]            rd_ptr_q;

  logic                     fifo_empty;
  logic                     fifo_full;
  logic [AXIS_DATA_WIDTH:0] fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[PtrW-1:0]];

  // ---------------------------------------------------------------------------
  // Register access decode
  // ---------------------------------------------------------------------------
  logic                  reg_wr;
  logic                  reg_rd;
  logic                  addr_hit;
  logic                  wr_control;
  logic                  wr_status;
  logic                  wr_ref_len;
  logic                  clear_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_wdata;

  // A write in the same cycle as a read request takes precedence; the read is dropped.
  assign reg_wr     = i_reg_in_rdy;
  assign reg_rd     = i_reg_out_req & ~i_reg_in_rdy;
  assign wr_control = reg_wr && (i_reg_address == AddrControl);
  assign wr_status  = reg_wr && (i_reg_address == AddrStatus);
  assign wr_ref_len = reg_wr && (i_reg_address == AddrRefLen);
  assign clear_cnt  = wr_control & i_reg_in_data[1];

  assign unused_wdata = ^i_reg_in_data;

  always_comb begin
    addr_hit = 1'b1;
    rd_data  = '0;
    case (i_reg_address)
      AddrControl: begin
        rd_data[0] = enable_q;
        rd_data[2] = strict_q;
      end
      AddrStatus: begin
        rd_data[0] = (state_q != StIdle);
        rd_data[1] = fifo_empty;
        rd_data[2] = fifo_full;
        rd_data[8] = short_err_q;
        rd_data[9] = long_err_q;
      end
      AddrRefLen:     rd_data[LEN_WIDTH-1:0] = ref_len_q;
      AddrVersion:    rd_data = DATA_WIDTH'(VersionValue);
      AddrKey:        rd_data = DATA_WIDTH'(KeyValue);
      AddrFrameCount: rd_data = DATA_WIDTH'(frame_cnt_q);
      AddrSampleCnt:  rd_data = DATA_WIDTH'(sample_cnt_q);
      default:        addr_hit = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stream framing
  // ---------------------------------------------------------------------------
  logic                 in_fire;
  logic                 out_pop;
  logic                 push;
  logic                 push_last;
  logic                 len_hit;
  logic                 set_short;
  logic                 set_long;
  logic [LEN_WIDTH:0]   cnt_next;

  assign o_axis_in_tready = (state_q == StDiscard) | (enable_q & ~fifo_full);
  assign in_fire          = i_axis_in_tvalid & o_axis_in_tready;
  assign out_pop          = o_axis_out_tvalid & i_axis_out_tready;

  // cnt_q counts samples already passed in this frame; cnt_next includes the current one.
  // REF_LEN of 0 or 1 makes every sample hit the length limit.
  assign cnt_next  = {1'b0, cnt_q} + (LEN_WIDTH + 1)'(1);
  assign len_hit   = (cnt_next >= {1'b0, ref_len_q});
  assign push      = in_fire & (state_q != StDiscard);
  assign push_last = len_hit | i_axis_in_tlast;
  assign set_short = push & i_axis_in_tlast & ~len_hit;
  assign set_long  = push & len_hit & ~i_axis_in_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (in_fire) begin
      case (state_q)
        StIdle, StPass: begin
          if (push_last) begin
            cnt_q   <= '0;
            state_q <= (set_long & strict_q) ? StDiscard : StIdle;
          end else begin
            cnt_q   <= cnt_next[LEN_WIDTH-1:0];
            state_q <= StPass;
          end
        end
        StDiscard: begin
          if (i_axis_in_tlast) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file, sticky flags and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q           <= 1'b0;
      strict_q           <= 1'b0;
      ref_len_q          <= '0;
      o_reg_in_ack_stb   <= 1'b0;
      o_reg_out_rdy_stb  <= 1'b0;
      o_reg_out_data     <= '0;
      o_reg_invalid_addr <= 1'b0;
    end else begin
      o_reg_in_ack_stb   <= reg_wr;
      o_reg_out_rdy_stb  <= reg_rd;
      o_reg_invalid_addr <= (reg_wr | reg_rd) & ~addr_hit;
      if (reg_rd) o_reg_out_data <= rd_data;
      if (wr_control) begin
        enable_q <= i_reg_in_data[0];
        strict_q <= i_reg_in_data[2];
      end
      if (wr_ref_len) ref_len_q <= i_reg_in_data[LEN_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      short_err_q <= 1'b0;
      long_err_q  <= 1'b0;
    end else begin
      // A new error event in the clearing cycle stays visible.
      short_err_q <= set_short | (short_err_q & ~(wr_status & i_reg_in_data[8]));
      long_err_q  <= set_long  | (long_err_q  & ~(wr_status & i_reg_in_data[9]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      frame_cnt_q  <= '0;
      sample_cnt_q <= '0;
    end else if (push) begin
      sample_cnt_q <= sample_cnt_q + 32'd1;
      if (push_last) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO; tlast travels with each entry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
      if (out_pop) rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= {push_last, i_axis_in_tdata};
  end

  assign o_axis_out_tvalid = ~fifo_empty;
  assign o_axis_out_tlast  = ~fifo_empty & fifo_head[AXIS_DATA_WIDTH];
  assign o_axis_out_tdata  = fifo_empty ? '0 : fifo_head[AXIS_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_dtw_stream_ctrl.sv
// Scoreboard bench for dtw_stream_ctrl: a frame-rule reference model predicts output beats and
// register reads; independent monitors compare whenever the DUT presents a beat or read strobe.
module tb_dtw_stream_ctrl;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 16;

  localparam logic [31:0] KeyValue     = 32'h0CA7_CAFE;
  localparam logic [31:0] VersionValue = 32'h2000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] i_reg_address = '0;
  logic          i_reg_in_rdy = 1'b0;
  logic [DW-1:0] i_reg_in_data = '0;
  logic          o_reg_in_ack_stb;
  logic          i_reg_out_req = 1'b0;
  logic          o_reg_out_rdy_stb;
  logic [DW-1:0] o_reg_out_data;
  logic          o_reg_invalid_addr;
  logic          i_axis_in_tvalid = 1'b0;
  logic          o_axis_in_tready;
  logic          i_axis_in_tlast = 1'b0;
  logic [SW-1:0] i_axis_in_tdata = '0;
  logic          o_axis_out_tvalid;
  logic          i_axis_out_tready = 1'b0;
  logic          o_axis_out_tlast;
  logic [SW-1:0] o_axis_out_tdata;

  always #5 clk = ~clk;

  dtw_stream_ctrl #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .AXIS_DATA_WIDTH(SW),
    .FIFO_DEPTH     (DEPTH),
    .LEN_WIDTH      (LW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_reg_address     (i_reg_address),
    .i_reg_in_rdy      (i_reg_in_rdy),
    .i_reg_in_data     (i_reg_in_data),
    .o_reg_in_ack_stb  (o_reg_in_ack_stb),
    .i_reg_out_req     (i_reg_out_req),
    .o_reg_out_rdy_stb (o_reg_out_rdy_stb),
    .o_reg_out_data    (o_reg_out_data),
    .o_reg_invalid_addr(o_reg_invalid_addr),
    .i_axis_in_tvalid  (i_axis_in_tvalid),
    .o_axis_in_tready  (o_axis_in_tready),
    .i_axis_in_tlast   (i_axis_in_tlast),
    .i_axis_in_tdata   (i_axis_in_tdata),
    .o_axis_out_tvalid (o_axis_out_tvalid),
    .i_axis_out_tready (i_axis_out_tready),
    .o_axis_out_tlast  (o_axis_out_tlast),
    .o_axis_out_tdata  (o_axis_out_tdata)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: frame position, drop mode, sticky flags and counters.
  logic [SW:0]   exp_q[$];
  logic [32:0]   rexp_q[$];
  int            m_ref_len;
  int            m_pos;
  bit            m_en, m_strict, m_short, m_long, m_drop;
  logic [31:0]   m_frames, m_samples;
  int            rdy_mode = 1;

  task automatic model_reset();
    m_ref_len = 0; m_pos = 0; m_en = 0; m_strict = 0;
    m_short = 0; m_long = 0; m_drop = 0;
    m_frames = '0; m_samples = '0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [31:0] d, input bit last);
    bit hit;
    if (m_drop) begin
      if (last) m_drop = 0;
      return;
    end
    m_pos++;
    hit = (m_pos >= m_ref_len);
    m_samples++;
    if (hit || last) begin
      exp_q.push_back({1'b1, d});
      m_frames++;
      if (last && !hit) m_short = 1;
      if (hit && !last) begin
        m_long = 1;
        if (m_strict) m_drop = 1;
      end
      m_pos = 0;
    end else begin
      exp_q.push_back({1'b0, d});
    end
  endtask

  function automatic bit is_mapped(input logic [15:0] a);
    return a inside {16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18};
  endfunction

  function automatic logic [31:0] exp_status(input bit empty, input bit full);
    logic [31:0] s;
    s    = '0;
    s[0] = (m_pos != 0) || m_drop;
    s[1] = empty;
    s[2] = full;
    s[8] = m_short;
    s[9] = m_long;
    return s;
  endfunction

  // Output-side ready pattern: 0 hold, 1 always ready, 2 random.
  always @(negedge clk) begin
    if (rdy_mode == 2) i_axis_out_tready = 1'($urandom_range(0, 1));
    else               i_axis_out_tready = (rdy_mode == 1);
  end

  // Stream monitor
  always @(negedge clk) begin
    #2;
    if (!rst && o_axis_out_tvalid && i_axis_out_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL out_unexpected: got beat 0x%0h tlast %0b, expected no beat",
                 o_axis_out_tdata, o_axis_out_tlast);
      end else begin
        check("out_beat", {o_axis_out_tlast, o_axis_out_tdata}, exp_q.pop_front());
      end
    end
  end

  // Register read monitor
  always @(negedge clk) begin
    #2;
    if (!rst && o_reg_out_rdy_stb) begin
      if (rexp_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got read strobe data 0x%0h, expected none", o_reg_out_data);
      end else begin
        check("rd_data_invalid", {o_reg_out_data, o_reg_invalid_addr}, rexp_q.pop_front());
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic cfg_write(input logic [15:0] a, input logic [31:0] d);
    bit inv;
    inv = !is_mapped(a);
    i_reg_address = a; i_reg_in_data = d; i_reg_in_rdy = 1'b1;
    @(negedge clk);
    i_reg_in_rdy = 1'b0;
    case (a)
      16'h00: begin
        m_en = d[0]; m_strict = d[2];
        if (d[1]) begin m_frames = '0; m_samples = '0; end
      end
      16'h04: begin
        if (d[8]) m_short = 0;
        if (d[9]) m_long = 0;
      end
      16'h08: m_ref_len = int'(d[LW-1:0]);
      default: ;
    endcase
    #3;
    check("wr_ack", o_reg_in_ack_stb, 1);
    check("wr_invalid", o_reg_invalid_addr, inv);
    @(negedge clk);
  endtask

  task automatic reg_read(input logic [15:0] a, input logic [31:0] exp);
    rexp_q.push_back({exp, !is_mapped(a)});
    i_reg_address = a; i_reg_out_req = 1'b1;
    @(negedge clk);
    i_reg_out_req = 1'b0;
    #3;
    check("rd_strobe", o_reg_out_rdy_stb, 1);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input bit last, input int budget, output bit ok);
    ok = 0;
    i_axis_in_tvalid = 1'b1; i_axis_in_tdata = d; i_axis_in_tlast = last;
    for (int c = 0; c < budget && !ok; c++) begin
      #1;
      if (o_axis_in_tready) begin
        model_accept(d, last);
        ok = 1;
      end
      @(negedge clk);
    end
    i_axis_in_tvalid = 1'b0; i_axis_in_tlast = 1'b0;
  endtask

  task automatic send_ok(input logic [31:0] d, input bit last);
    bit ok;
    send(d, last, 64, ok);
    check("in_accept", ok, 1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("drain_done", exp_q.size(), 0);
    #1;
    check("fifo_empty_after_drain", o_axis_out_tvalid, 0);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_invalid_addr, o_axis_in_tready,
                 o_axis_out_tvalid, o_axis_out_tlast}, 0);
    check({name, "_data"}, {o_reg_out_data, o_axis_out_tdata}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    check_idle_outputs("reset_outputs");
    @(negedge clk);

    // Register file
    cfg_write(16'h08, 32'd5);
    reg_read(16'h08, 32'd5);
    reg_read(16'h10, KeyValue);
    reg_read(16'h0C, VersionValue);
    reg_read(16'h24, 32'd0);
    cfg_write(16'h30, 32'hFFFF_FFFF);
    reg_read(16'h04, exp_status(1, 0));
    cfg_write(16'h00, 32'h7);
    reg_read(16'h00, 32'h5);
    cfg_write(16'h00, 32'h0);

    // Write and read in the same cycle: only the write is serviced
    i_reg_address = 16'h08; i_reg_in_data = 32'd7; i_reg_in_rdy = 1'b1; i_reg_out_req = 1'b1;
    @(negedge clk);
    i_reg_in_rdy = 1'b0; i_reg_out_req = 1'b0;
    m_ref_len = 7;
    #3;
    check("both_ack", o_reg_in_ack_stb, 1);
    check("both_no_read", o_reg_out_rdy_stb, 0);
    @(negedge clk);
    reg_read(16'h08, 32'd7);

    // Length-only framing: 8 samples, REF_LEN=4
    rdy_mode = 1;
    cfg_write(16'h00, 32'h3);
    cfg_write(16'h08, 32'd4);
    for (int i = 0; i < 8; i++) send_ok(32'h100 + i, 1'b0);
    drain();
    reg_read(16'h14, m_frames);
    reg_read(16'h18, m_samples);
    reg_read(16'h04, exp_status(1, 0));
    cfg_write(16'h04, 32'h300);

    // Short frame and W1C
    send_ok(32'h200, 1'b0);
    send_ok(32'h201, 1'b1);
    drain();
    reg_read(16'h04, exp_status(1, 0));
    cfg_write(16'h04, 32'h100);
    reg_read(16'h04, exp_status(1, 0));

    // Overlong frame with tlast required: tail dropped
    cfg_write(16'h00, 32'h5);
    cfg_write(16'h08, 32'd3);
    for (int i = 0; i < 6; i++) send_ok(32'h300 + i, i == 5);
    drain();
    reg_read(16'h04, exp_status(1, 0));
    reg_read(16'h18, m_samples);
    cfg_write(16'h04, 32'h300);

    // Enable dropped mid-frame holds the frame
    cfg_write(16'h00, 32'h1);
    cfg_write(16'h08, 32'd4);
    send_ok(32'h400, 1'b0);
    send_ok(32'h401, 1'b0);
    cfg_write(16'h00, 32'h0);
    send(32'h402, 1'b0, 4, ok);
    check("disabled_not_accepted", ok, 0);
    drain();
    reg_read(16'h04, exp_status(1, 0));
    cfg_write(16'h00, 32'h1);
    send_ok(32'h402, 1'b0);
    send_ok(32'h403, 1'b0);
    drain();

    // Backpressure: FIFO fills to DEPTH
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(32'h500 + i, (i % 4) == 3, 3, ok);
      if (ok) acc++;
    end
    check("bp_accepted", acc, DEPTH);
    #1;
    check("bp_tready_low", o_axis_in_tready, 0);
    check("bp_tvalid", o_axis_out_tvalid, 1);
    @(negedge clk);
    reg_read(16'h04, exp_status(0, 1));
    rdy_mode = 1;
    drain();

    // Randomised traffic with random output stalls
    rdy_mode = 2;
    for (int b = 0; b < 12; b++) begin
      if (m_pos == 0 && !m_drop) cfg_write(16'h08, $urandom_range(0, 6));
      cfg_write(16'h00, 32'h1 | ($urandom_range(0, 1) << 2));
      for (int i = 0; i < 25; i++) begin
        send_ok($urandom, $urandom_range(0, 4) == 0);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end
    drain();
    reg_read(16'h14, m_frames);
    reg_read(16'h18, m_samples);
    reg_read(16'h04, exp_status(1, 0));

    // Reset mid-frame
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    cfg_write(16'h00, 32'h1);
    cfg_write(16'h08, 32'd4);
    send_ok(32'h600, 1'b0);
    send_ok(32'h601, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #3;
    check_idle_outputs("midreset_outputs");
    @(negedge clk);
    reg_read(16'h14, 32'd0);
    reg_read(16'h18, 32'd0);
    reg_read(16'h08, 32'd0);
    reg_read(16'h04, exp_status(1, 0));
    rdy_mode = 1;
    cfg_write(16'h00, 32'h1);
    cfg_write(16'h08, 32'd4);
    for (int i = 0; i < 4; i++) send_ok(32'h700 + i, 1'b0);
    drain();
    reg_read(16'h14, m_frames);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("read_queue_empty", rexp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
